rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between the pipeline writeback stage (regWriteW path) and a long-latency unit (LU, e.g. mul/div).
- Keeps a 32-entry scoreboard of LU destinations in flight and raises decode-stage RAW/WAW stalls.
- Sits between writeback/LU and registerFile. It drives registerFile's write index, data and enable.

---
 rtl/rf_write_arbiter_pkg.sv | 20 ++
 rtl/rf_write_arbiter_if.sv | 48 ++++
 rtl/rf_write_arbiter_scoreboard.sv | 47 ++++
 rtl/rf_write_arbiter.sv | 101 ++++++++++
 tb/tb_rf_write_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared processor definitions for the register-file write arbiter:
// register geometry, the arbiter state encoding and the hard-wired zero register.
package rf_write_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

  function automatic logic is_reg_zero(input logic [ADDR_W-1:0] idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundles the writeback, long-latency unit, issue, decode and register-file
// signals around the write arbiter; the master side drives the requests.
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;

  logic [ADDR_W-1:0] dec_rs1;
  logic [ADDR_W-1:0] dec_rs2;
  logic [ADDR_W-1:0] dec_rd;
  logic              hazard_stall;
  logic              wb_stall;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_index;
  logic [DATA_W-1:0] rf_wdata;

  logic [NUM_REGS-1:0] pending;

  modport master (
    output wb_we, wb_rd, wb_data,
    output lu_valid, lu_rd, lu_data,
    output iss_valid, iss_rd,
    output dec_rs1, dec_rs2, dec_rd,
    input  lu_ready, hazard_stall, wb_stall,
    input  rf_we, rf_index, rf_wdata, pending
  );

  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  lu_valid, lu_rd, lu_data,
    input  iss_valid, iss_rd,
    input  dec_rs1, dec_rs2, dec_rd,
    output lu_ready, hazard_stall, wb_stall,
    output rf_we, rf_index, rf_wdata, pending
  );

endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// Pending-destination scoreboard for long-latency ops plus the decode-stage
// hazard compare over rs1/rs2/rd.
module rf_scoreboard
  import rf_write_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_valid,
  input  logic [ADDR_W-1:0]   set_idx,
  input  logic                clr_valid,
  input  logic [ADDR_W-1:0]   clr_idx,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                force_stall,
  output logic [NUM_REGS-1:0] pending,
  output logic                hazard
);

  logic [NUM_REGS-1:0] pending_next;

  function automatic logic operand_busy(input logic [ADDR_W-1:0] idx,
                                        input logic [NUM_REGS-1:0] mask);
    return !is_reg_zero(idx) && mask[idx];
  endfunction

  // Clear first so that a new claim on the same register in the same cycle survives.
  always_comb begin
    pending_next = pending;
    if (clr_valid)
      pending_next[clr_idx] = 1'b0;
    if (set_valid && !is_reg_zero(set_idx))
      pending_next[set_idx] = 1'b1;
    pending_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pending_next;
  end

  assign hazard = operand_busy(rs1, pending) | operand_busy(rs2, pending) |
                  operand_busy(rd, pending)  | force_stall;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between writeback and a
// long-latency unit, holding LU results until writeback leaves a gap or ages out.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  arb_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] hold_rd;
  logic [DATA_W-1:0] hold_data;
  logic              lu_ready_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_index_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic wb_stall;
  logic lu_grant;
  logic wb_grant;

  // A held result is forced out once writeback has beaten it MAX_WAIT times.
  assign wb_stall = (state == HOLD) && bus.wb_we && (wait_cnt == MAX_CNT);
  assign lu_grant = (state == HOLD) && (!bus.wb_we || wait_cnt == MAX_CNT);
  assign wb_grant = bus.wb_we && !wb_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      hold_rd    <= '0;
      hold_data  <= '0;
      lu_ready_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_index_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (wb_grant) begin
        rf_we_q    <= !is_reg_zero(bus.wb_rd);
        rf_index_q <= bus.wb_rd;
        rf_wdata_q <= bus.wb_data;
      end else if (lu_grant) begin
        rf_we_q    <= !is_reg_zero(hold_rd);
        rf_index_q <= hold_rd;
        rf_wdata_q <= hold_data;
      end

      case (state)
        IDLE: begin
          lu_ready_q <= 1'b1;
          if (bus.lu_valid && lu_ready_q) begin
            hold_rd    <= bus.lu_rd;
            hold_data  <= bus.lu_data;
            wait_cnt   <= '0;
            lu_ready_q <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (lu_grant) begin
            lu_ready_q <= 1'b1;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_valid  (bus.iss_valid),
    .set_idx    (bus.iss_rd),
    .clr_valid  (lu_grant),
    .clr_idx    (hold_rd),
    .rs1        (bus.dec_rs1),
    .rs2        (bus.dec_rs2),
    .rd         (bus.dec_rd),
    .force_stall(wb_stall),
    .pending    (bus.pending),
    .hazard     (bus.hazard_stall)
  );

  assign bus.wb_stall = wb_stall;
  assign bus.lu_ready = lu_ready_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_index = rf_index_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, writeback, contention ageing,
// scoreboard hazards, register zero and reset while a result is held.
module tb_rf_write_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.MAX_WAIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_rd     = '0;
    bus.lu_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.dec_rs1   = '0;
    bus.dec_rs2   = '0;
    bus.dec_rd    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_lu_ready_in_reset: got %0b expected 0", bus.lu_ready); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.rf_index !== 5'd0) begin errors++; $display("[TB] FAIL reset_rf_index: got %0d expected 0", bus.rf_index); end
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 0", bus.pending); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_lu_ready_after: got %0b expected 1", bus.lu_ready); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %0b expected 0", bus.hazard_stall); end
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_stall: got %0b expected 0", bus.wb_stall); end
  endtask

  task automatic test_wb_only();
    bus.wb_we   = 1'b1;
    bus.wb_rd   = 5'd1;
    bus.wb_data = 32'h0002_0000;
    #1;
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("[TB] FAIL wb_only_wb_stall: got %0b expected 0", bus.wb_stall); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL wb_only_hazard: got %0b expected 0", bus.hazard_stall); end
    step();
    bus.wb_we = 1'b0;
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL wb_only_rf_we: got %0b expected 1", bus.rf_we); end
    checks++; if (bus.rf_index !== 5'd1) begin errors++; $display("[TB] FAIL wb_only_rf_index: got %0d expected 1", bus.rf_index); end
    checks++; if (bus.rf_wdata !== 32'h0002_0000) begin errors++; $display("[TB] FAIL wb_only_rf_wdata: got %h expected 00020000", bus.rf_wdata); end
    step();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL wb_only_idle_rf_we: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.rf_index !== 5'd1) begin errors++; $display("[TB] FAIL wb_only_idle_index_hold: got %0d expected 1", bus.rf_index); end
  endtask

  task automatic test_contention();
    bus.wb_we    = 1'b1;
    bus.wb_rd    = 5'd2;
    bus.wb_data  = 32'h0000_00A0;
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd5;
    bus.lu_data  = 32'hDEAD_BEEF;
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.rf_index !== 5'd2) begin errors++; $display("[TB] FAIL cont_capture_wb_index: got %0d expected 2", bus.rf_index); end
    checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("[TB] FAIL cont_lu_ready_hold: got %0b expected 0", bus.lu_ready); end
    for (int i = 0; i < 4; i++) begin
      bus.wb_rd   = 5'(10 + i);
      bus.wb_data = 32'(256 + i);
      #1;
      checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("[TB] FAIL cont_wb_stall_%0d: got %0b expected 0", i, bus.wb_stall); end
      step();
      checks++; if (bus.rf_index !== 5'(10 + i) || bus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL cont_wb_grant_%0d: got we=%0b idx=%0d expected we=1 idx=%0d", i, bus.rf_we, bus.rf_index, 10 + i); end
    end
    bus.wb_rd   = 5'd20;
    bus.wb_data = 32'h0000_2020;
    #1;
    checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("[TB] FAIL cont_forced_wb_stall: got %0b expected 1", bus.wb_stall); end
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL cont_forced_hazard: got %0b expected 1", bus.hazard_stall); end
    step();
    checks++; if (bus.rf_index !== 5'd5 || bus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL cont_lu_index: got we=%0b idx=%0d expected we=1 idx=5", bus.rf_we, bus.rf_index); end
    checks++; if (bus.rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL cont_lu_data: got %h expected deadbeef", bus.rf_wdata); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("[TB] FAIL cont_lu_ready_back: got %0b expected 1", bus.lu_ready); end
    #1;
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("[TB] FAIL cont_retry_wb_stall: got %0b expected 0", bus.wb_stall); end
    step();
    bus.wb_we = 1'b0;
    checks++; if (bus.rf_index !== 5'd20 || bus.rf_wdata !== 32'h0000_2020) begin errors++; $display("[TB] FAIL cont_retry_write: got idx=%0d data=%h expected idx=20 data=00002020", bus.rf_index, bus.rf_wdata); end
    step();
  endtask

  task automatic test_scoreboard_raw();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    step();
    bus.iss_valid = 1'b0;
    checks++; if (bus.pending !== 32'h0000_0080) begin errors++; $display("[TB] FAIL raw_pending_set: got %h expected 00000080", bus.pending); end
    bus.dec_rs2 = 5'd7;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_hazard_rs2: got %0b expected 1", bus.hazard_stall); end
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd7;
    bus.lu_data  = 32'h0000_0077;
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_hazard_held: got %0b expected 1", bus.hazard_stall); end
    step();
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL raw_hazard_cleared: got %0b expected 0", bus.hazard_stall); end
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("[TB] FAIL raw_pending_cleared: got %h expected 0", bus.pending); end
    checks++; if (bus.rf_index !== 5'd7 || bus.rf_wdata !== 32'h0000_0077 || bus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL raw_lu_write: got we=%0b idx=%0d data=%h expected we=1 idx=7 data=00000077", bus.rf_we, bus.rf_index, bus.rf_wdata); end
    bus.dec_rs2 = 5'd0;
  endtask

  task automatic test_set_wins();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd8;
    step();
    bus.dec_rd   = 5'd8;
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd8;
    bus.lu_data  = 32'h0000_0088;
    bus.iss_valid = 1'b0;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL setwin_hazard_rd: got %0b expected 1", bus.hazard_stall); end
    step();
    bus.lu_valid  = 1'b0;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd8;
    step();
    bus.iss_valid = 1'b0;
    bus.dec_rd    = 5'd0;
    checks++; if (bus.pending !== 32'h0000_0100) begin errors++; $display("[TB] FAIL setwin_pending: got %h expected 00000100", bus.pending); end
    checks++; if (bus.rf_index !== 5'd8 || bus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL setwin_lu_write: got we=%0b idx=%0d expected we=1 idx=8", bus.rf_we, bus.rf_index); end
  endtask

  task automatic test_reg_zero();
    bus.wb_we     = 1'b1;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'h1111_1111;
    bus.lu_valid  = 1'b1;
    bus.lu_rd     = 5'd0;
    bus.lu_data   = 32'h2222_2222;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    step();
    idle_inputs();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL zero_wb_rf_we: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_lu_ready_hold: got %0b expected 0", bus.lu_ready); end
    checks++; if (bus.pending !== 32'h0000_0100) begin errors++; $display("[TB] FAIL zero_pending_iss: got %h expected 00000100", bus.pending); end
    step();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL zero_lu_rf_we: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_lu_ready_back: got %0b expected 1", bus.lu_ready); end
    checks++; if (bus.pending !== 32'h0000_0100) begin errors++; $display("[TB] FAIL zero_pending_after: got %h expected 00000100", bus.pending); end
  endtask

  task automatic test_reset_mid_hold();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    step();
    bus.iss_valid = 1'b0;
    bus.lu_valid  = 1'b1;
    bus.lu_rd     = 5'd9;
    bus.lu_data   = 32'h0000_0099;
    bus.wb_we     = 1'b1;
    bus.wb_rd     = 5'd4;
    bus.wb_data   = 32'h0000_0044;
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.pending !== 32'h0000_0300) begin errors++; $display("[TB] FAIL rsthold_pending_before: got %h expected 00000300", bus.pending); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_index !== 5'd4) begin errors++; $display("[TB] FAIL rsthold_wb_write: got we=%0b idx=%0d expected we=1 idx=4", bus.rf_we, bus.rf_index); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("[TB] FAIL rsthold_pending_async: got %h expected 0", bus.pending); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_rf_we_async: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.rf_index !== 5'd0) begin errors++; $display("[TB] FAIL rsthold_rf_index_async: got %0d expected 0", bus.rf_index); end
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_no_write_%0d: got %0b expected 0", i, bus.rf_we); end
    end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_lu_ready: got %0b expected 1", bus.lu_ready); end
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("[TB] FAIL rsthold_pending_after: got %h expected 0", bus.pending); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_wb_only();
    test_contention();
    test_scoreboard_raw();
    test_set_wins();
    test_reg_zero();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
